// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The master drives the request side and the slave returns status and results.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;

  modport master (
    output start, A, B, Cin,
    input  busy, done, S, Cout
  );

  modport slave (
    input  start, A, B, Cin,
    output busy, done, S, Cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// The A shift register doubles as the sum assembly register as its bits are consumed.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             accept;
  logic             shift_en;
  logic             complete;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] a_shift;
  logic             carry_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;

  logic             fa_s;
  logic             fa_c;

  assign fa_s = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_c = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

  // Each sum bit enters at the MSB, so after WIDTH shifts the register holds the sum LSB-aligned.
  generate
    if (WIDTH == 1) begin : g_single
      assign a_shift = fa_s;
    end else begin : g_multi
      assign a_shift = {fa_s, a_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    shift_en = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (count_q == LAST) begin
          complete = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Results update only on completion, so they hold through IDLE and the next add.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      if (accept) begin
        a_q     <= bus.A;
        b_q     <= bus.B;
        carry_q <= bus.Cin;
        count_q <= '0;
      end else if (shift_en) begin
        a_q     <= a_shift;
        b_q     <= b_q >> 1;
        carry_q <= fa_c;
        count_q <= count_q + CW'(1);
      end
      if (complete) begin
        s_q    <= a_shift;
        cout_q <= fa_c;
      end
    end
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.S    = s_q;
  assign bus.Cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic cin);
    bus8.A     = a;
    bus8.B     = b;
    bus8.Cin   = cin;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
  endtask

  // Bounded wait for the done pulse, counting busy cycles on the way.
  task automatic waitDone(output int busy_cycles, output logic seen);
    busy_cycles = 0;
    seen        = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (bus8.done) begin
        seen = 1'b1;
        break;
      end
      if (bus8.busy) busy_cycles++;
      tick();
    end
  endtask

  task automatic runAdd(input string tag, input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [7:0] exp_s, input logic exp_c);
    int   bc;
    logic seen;
    applyStimulus(a, b, cin);
    waitDone(bc, seen);
    checkOutput({tag, "_done"}, 32'(seen), 32'd1);
    checkOutput({tag, "_busy"}, 32'(bc), 32'd8);
    checkOutput({tag, "_S"}, 32'(bus8.S), 32'(exp_s));
    checkOutput({tag, "_Cout"}, 32'(bus8.Cout), 32'(exp_c));
  endtask

  initial begin
    int          bc;
    logic        seen;
    int          done_count;
    logic [7:0]  ra, rb;
    logic        rc;
    logic [8:0]  rexp;

    bus8.start = 1'b0; bus8.A = '0; bus8.B = '0; bus8.Cin = 1'b0;
    bus1.start = 1'b0; bus1.A = '0; bus1.B = '0; bus1.Cin = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    checkOutput("rst_busy", 32'(bus8.busy), 32'd0);
    checkOutput("rst_done", 32'(bus8.done), 32'd0);
    checkOutput("rst_S", 32'(bus8.S), 32'd0);
    checkOutput("rst_Cout", 32'(bus8.Cout), 32'd0);
    checkOutput("rst1_S", 32'(bus1.S), 32'd0);
    checkOutput("rst1_Cout", 32'(bus1.Cout), 32'd0);

    runAdd("t1", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    tick();
    checkOutput("t1_idle_done", 32'(bus8.done), 32'd0);
    checkOutput("t1_idle_busy", 32'(bus8.busy), 32'd0);
    checkOutput("t1_hold_S", 32'(bus8.S), 32'h96);

    runAdd("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    runAdd("t2b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // start held high: a new add every 9 cycles, operand changes mid-SHIFT ignored
    bus8.A = 8'h10; bus8.B = 8'h20; bus8.Cin = 1'b0; bus8.start = 1'b1;
    tick();
    for (int r = 0; r < 3; r++) begin
      checkOutput("t3_busy", 32'(bus8.busy), 32'd1);
      for (int k = 0; k < 8; k++) begin
        if (k == 3) begin bus8.A = 8'hAA; bus8.B = 8'h77; end
        if (k == 6) begin bus8.A = 8'h10; bus8.B = 8'h20; end
        tick();
      end
      checkOutput("t3_done", 32'(bus8.done), 32'd1);
      checkOutput("t3_S", 32'(bus8.S), 32'h30);
      checkOutput("t3_Cout", 32'(bus8.Cout), 32'd0);
      if (r < 2) tick();
    end
    bus8.start = 1'b0;
    tick();
    checkOutput("t3_end_busy", 32'(bus8.busy), 32'd0);

    // reset three cycles into an add
    applyStimulus(8'hFF, 8'hFF, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t4_busy", 32'(bus8.busy), 32'd0);
    checkOutput("t4_done", 32'(bus8.done), 32'd0);
    checkOutput("t4_S", 32'(bus8.S), 32'd0);
    checkOutput("t4_Cout", 32'(bus8.Cout), 32'd0);
    done_count = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus8.done) done_count++;
      tick();
    end
    checkOutput("t4_no_done", 32'(done_count), 32'd0);

    // back-to-back accept in the DONE cycle
    applyStimulus(8'h40, 8'h05, 1'b0);
    waitDone(bc, seen);
    checkOutput("t5a_done", 32'(seen), 32'd1);
    checkOutput("t5a_S", 32'(bus8.S), 32'h45);
    bus8.A = 8'h01; bus8.B = 8'h02; bus8.Cin = 1'b0; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    checkOutput("t5_busy", 32'(bus8.busy), 32'd1);
    checkOutput("t5_done_low", 32'(bus8.done), 32'd0);
    checkOutput("t5_hold_S", 32'(bus8.S), 32'h45);
    waitDone(bc, seen);
    checkOutput("t5b_done", 32'(seen), 32'd1);
    checkOutput("t5b_busy", 32'(bc), 32'd8);
    checkOutput("t5b_S", 32'(bus8.S), 32'h03);

    // WIDTH=1 instance
    bus1.A = 1'b1; bus1.B = 1'b1; bus1.Cin = 1'b1; bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    checkOutput("t6_busy", 32'(bus1.busy), 32'd1);
    checkOutput("t6_done_low", 32'(bus1.done), 32'd0);
    tick();
    checkOutput("t6_done", 32'(bus1.done), 32'd1);
    checkOutput("t6_S", 32'(bus1.S), 32'd1);
    checkOutput("t6_Cout", 32'(bus1.Cout), 32'd1);
    bus1.A = 1'b1; bus1.B = 1'b0; bus1.Cin = 1'b1; bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    tick();
    checkOutput("t6b_done", 32'(bus1.done), 32'd1);
    checkOutput("t6b_S", 32'(bus1.S), 32'd0);
    checkOutput("t6b_Cout", 32'(bus1.Cout), 32'd1);
    tick();
    checkOutput("t6_idle", 32'(bus1.done), 32'd0);

    // random sweep against the A+B+Cin model
    for (int n = 0; n < 1000; n++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rc   = 1'($urandom);
      rexp = 9'(ra) + 9'(rb) + 9'(rc);
      applyStimulus(ra, rb, rc);
      waitDone(bc, seen);
      checkOutput("rand", {22'd0, seen, bus8.Cout, bus8.S}, {22'd0, 1'b1, rexp});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
